// File: rtl/fht_twiddle_seq.sv
// Twiddle-factor address sequencer for the FHT datapath.
// Tags each registered ROM coefficient with its stage/butterfly.
module fht_twiddle_seq #(
  parameter int A_BIT = 6,
  parameter int S_BIT = 3
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iREADY,
  output logic [A_BIT-1:0] oADDR,
  output logic             oST_ZERO,
  output logic             oVALID,
  output logic [S_BIT-1:0] oSTAGE,
  output logic [A_BIT-1:0] oBFLY,
  output logic             oLAST,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [S_BIT-1:0] LAST_STAGE = S_BIT'(A_BIT);
  localparam logic [A_BIT-1:0] BMAX = '1;

  logic [1:0]       state;
  logic [S_BIT-1:0] stage_n;
  logic [S_BIT-1:0] stage_d;
  logic [A_BIT-1:0] bfly_n;
  logic [A_BIT-1:0] bfly_d;
  logic             run;
  logic             accept;
  logic             final_item;

  // Keep only the top s bits of the butterfly index.
  function automatic logic [A_BIT-1:0] twiddle(
    input logic [S_BIT-1:0] s,
    input logic [A_BIT-1:0] b
  );
    logic [A_BIT-1:0] m;
    for (int i = 0; i < A_BIT; i++)
      m[i] = b[i] & ((int'(s) + i) >= A_BIT);
    return m;
  endfunction

  assign run        = (state == RUN);
  assign accept     = run & iREADY;
  assign final_item = (stage_d == LAST_STAGE)
                    && (bfly_d == BMAX);

  // On a stall the held address is re-presented so ROM data stays put.
  always_comb begin
    oADDR = '0;
    case (state)
      PRIME:   oADDR = twiddle('0, '0);
      RUN:     oADDR = accept ? twiddle(stage_n, bfly_n)
                              : twiddle(stage_d, bfly_d);
      default: oADDR = '0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state   <= IDLE;
      stage_n <= '0;
      bfly_n  <= '0;
      stage_d <= '0;
      bfly_d  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            stage_n <= '0;
            bfly_n  <= '0;
            state   <= PRIME;
          end
        end
        PRIME: begin
          stage_d <= '0;
          bfly_d  <= '0;
          stage_n <= '0;
          bfly_n  <= A_BIT'(1);
          state   <= RUN;
        end
        RUN: begin
          if (accept) begin
            if (final_item) begin
              state <= DONE;
            end else begin
              stage_d <= stage_n;
              bfly_d  <= bfly_n;
              bfly_n  <= bfly_n + 1'b1;
              if (bfly_n == BMAX)
                stage_n <= stage_n + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oVALID   = run;
  assign oST_ZERO = run & (stage_d == '0);
  assign oLAST    = run & (bfly_d == BMAX);
  assign oSTAGE   = stage_d;
  assign oBFLY    = bfly_d;
  assign oBUSY    = (state != IDLE);
  assign oDONE    = (state == DONE);

endmodule
